// File: rtl/timer_pkg.sv
// timer_pkg: shared definitions for the 16-bit timer prescaler, core and register model.
//   NSEL       default number of divide selections
//   SEL_W      width of a divide code
//   sel_t      divide code type
//   sel_to_div returns the divide ratio 2^(k+1) for code k
package timer_pkg;

    localparam int NSEL  = 4;
    localparam int SEL_W = (NSEL > 1) ? $clog2(NSEL) : 1;

    typedef logic [SEL_W-1:0] sel_t;

    function automatic logic [31:0] sel_to_div(sel_t k);
        return 32'd1 << (32'(k) + 32'd1);
    endfunction

endpackage

// File: rtl/prescaler_sync.sv
// prescaler_sync: 2-flop synchronizer for an asynchronous count source plus a
// rising-edge detector producing a one-clk pulse.
//   clk      in   system clock
//   rst      in   synchronous reset, active-high
//   async_i  in   asynchronous input
//   rise_o   out  one-clk pulse, high two clk edges after async_i rises
module prescaler_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic rise_o
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = async_i;
        sync_d = meta_q;
        prev_d = sync_q;
        rise_o = sync_q & ~prev_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

endmodule

// File: rtl/timer_prescaler.sv
// timer_prescaler: glitch-free clock prescaler for the 16-bit timer.
// Divides pclk by D = 2^(k+1), k = divide code in effect. A new code is only
// taken at the end of a period (or immediately while disabled), so clk_in
// never shows a runt phase.
//   pclk       in   system clock
//   rst        in   synchronous reset, active-high
//   en         in   prescaler enable
//   cks        in   requested divide code (values >= NSEL clamp to NSEL-1)
//   clk_in     out  divided clock, registered, 50% duty, period D
//   tick_o     out  one-pclk pulse at the end of every period
//   sel_act_o  out  divide code currently in effect
// Optional build macro PRESCALER_EXT_CLK_EN adds:
//   ext_clk    in   asynchronous external count source
//   ext_sel    in   1: count only on synchronized ext_clk rising edges
module timer_prescaler
    import timer_pkg::*;
#(
    parameter int NSEL  = timer_pkg::NSEL,
    parameter int SEL_W = (NSEL > 1) ? $clog2(NSEL) : 1,
    parameter int CNT_W = NSEL
) (
`ifdef PRESCALER_EXT_CLK_EN
    input  logic             ext_clk,
    input  logic             ext_sel,
`endif
    input  logic             pclk,
    input  logic             rst,
    input  logic             en,
    input  logic [SEL_W-1:0] cks,
    output logic             clk_in,
    output logic             tick_o,
    output logic [SEL_W-1:0] sel_act_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clk_in_q, clk_in_d;
    logic             tick_q, tick_d;
    logic [SEL_W-1:0] sel_act_q, sel_act_d;

    logic [31:0]      div_full;
    logic [CNT_W-1:0] div_m1;
    logic [CNT_W-1:0] div_half;
    logic [CNT_W-1:0] cnt_nxt;
    logic [SEL_W-1:0] cks_clamp;
    logic             wrap;
    logic             count_en;

`ifdef PRESCALER_EXT_CLK_EN
    logic ext_rise;

    prescaler_sync u_sync (
        .clk     (pclk),
        .rst     (rst),
        .async_i (ext_clk),
        .rise_o  (ext_rise)
    );

    assign count_en = ~ext_sel | ext_rise;
`else
    assign count_en = 1'b1;
`endif

    always_comb begin
        div_full  = sel_to_div(sel_t'(sel_act_q));
        div_m1    = CNT_W'(div_full - 32'd1);
        div_half  = CNT_W'(div_full >> 1);
        wrap      = (cnt_q == div_m1);
        cnt_nxt   = wrap ? '0 : cnt_q + 1'b1;
        cks_clamp = (32'(cks) >= 32'(NSEL)) ? SEL_W'(NSEL - 1) : cks;
    end

    always_comb begin
        cnt_d     = cnt_q;
        clk_in_d  = clk_in_q;
        tick_d    = 1'b0;
        sel_act_d = sel_act_q;
        if (!en) begin
            // Idle: discard any partial period and track cks directly.
            cnt_d     = '0;
            clk_in_d  = 1'b0;
            sel_act_d = cks_clamp;
        end else if (count_en) begin
            cnt_d    = cnt_nxt;
            clk_in_d = (cnt_nxt >= div_half);
            tick_d   = wrap;
            if (wrap) begin
                sel_act_d = cks_clamp;
            end
        end
        // With an external source, non-counting edges hold the count and
        // clk_in; tick_o drops so it stays a single-pclk enable.
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            cnt_q     <= '0;
            clk_in_q  <= 1'b0;
            tick_q    <= 1'b0;
            sel_act_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            clk_in_q  <= clk_in_d;
            tick_q    <= tick_d;
            sel_act_q <= sel_act_d;
        end
    end

    assign clk_in    = clk_in_q;
    assign tick_o    = tick_q;
    assign sel_act_o = sel_act_q;

endmodule
